placar_partida: RTL and testbench

- Match controller downstream of the ball/paddle game core. It consumes one-cycle goal pulses, keeps both scores, and runs the serve countdown and match-over sequence.
- It gates ball motion through `bola_liberada` and drives all six HEX displays, replacing direct score-to-HEX wiring.
- It sits in the `VGA_CLK` domain, alongside the paddle instances.

---
 rtl/placar_partida_pkg.sv | 34 +++
 rtl/placar_partida_hex7seg.sv | 34 +++
 rtl/placar_partida.sv | 155 +++++++++++++++
 tb/tb_placar_partida.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/placar_partida_pkg.sv
// Shared types and helpers for the match controller: FSM states, winner codes,
// blank HEX pattern and small score arithmetic used by the display path.
package placar_partida_pkg;

  typedef enum logic [2:0] {
    ESTADO_ESPERA,
    ESTADO_SAQUE,
    ESTADO_JOGO,
    ESTADO_PONTO,
    ESTADO_FIM
  } estado_t;

  localparam logic [1:0] VENC_NENHUM = 2'd0;
  localparam logic [1:0] VENC_ESQ    = 2'd1;
  localparam logic [1:0] VENC_DIR    = 2'd2;

  localparam logic [6:0] HEX_APAGADO = 7'b1111111;

  localparam int PONTOS_VITORIA_PADRAO = 7;

  // Scores stop at 15 instead of wrapping back to 0.
  function automatic logic [3:0] incr_sat(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] dezena(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] unidade(input logic [3:0] v);
    return (v >= 4'd10) ? v - 4'd10 : v;
  endfunction

endpackage

// File: rtl/placar_partida_hex7seg.sv
// Hex digit to active-low 7-segment decoder with a blank override.
module hex7seg
  import placar_partida_pkg::*;
(
  input  logic [3:0] valor_i,
  input  logic       apagado_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_APAGADO;
    if (!apagado_i) begin
      case (valor_i)
        4'h0: seg_o = 7'b1000000;
        4'h1: seg_o = 7'b1111001;
        4'h2: seg_o = 7'b0100100;
        4'h3: seg_o = 7'b0110000;
        4'h4: seg_o = 7'b0011001;
        4'h5: seg_o = 7'b0010010;
        4'h6: seg_o = 7'b0000010;
        4'h7: seg_o = 7'b1111000;
        4'h8: seg_o = 7'b0000000;
        4'h9: seg_o = 7'b0010000;
        4'hA: seg_o = 7'b0001000;
        4'hB: seg_o = 7'b0000011;
        4'hC: seg_o = 7'b1000110;
        4'hD: seg_o = 7'b0100001;
        4'hE: seg_o = 7'b0000110;
        default: seg_o = 7'b0001110;
      endcase
    end
  end

endmodule

// File: rtl/placar_partida.sv
// Match controller: counts goals, runs the serve countdown and the match-over
// sequence, gates ball motion and drives the six HEX displays.
module placar_partida
  import placar_partida_pkg::*;
#(
  parameter int PONTOS_VITORIA = PONTOS_VITORIA_PADRAO,
  parameter int CICLOS_SEGUNDO = 25000000,
  parameter int SAQUE_SEGUNDOS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       gol_esq,
  input  logic       gol_dir,
  output logic       bola_liberada,
  output logic       recentra,
  output logic       saque_dir,
  output logic [3:0] placar_esq,
  output logic [3:0] placar_dir,
  output logic [1:0] vencedor,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam int PW   = (CICLOS_SEGUNDO > 1) ? $clog2(CICLOS_SEGUNDO) : 1;
  localparam int MEIO = (CICLOS_SEGUNDO / 2 > 1) ? CICLOS_SEGUNDO / 2 : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CICLOS_SEGUNDO - 1);
  localparam logic [PW-1:0] MEIO_MAX  = PW'(MEIO - 1);
  localparam logic [3:0]    PV        = 4'(PONTOS_VITORIA);
  localparam logic [3:0]    SEG_INI   = 4'(SAQUE_SEGUNDOS);

  estado_t       estado_q;
  logic          ini_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    seg_q;
  logic          bola_q, recentra_q, saque_dir_q, pisca_q;
  logic [3:0]    esq_q, dir_q;
  logic [1:0]    venc_q;

  logic ini_d;
  assign ini_d = iniciar & ~ini_q;

  // The prescaler is shared: whole seconds during the serve, half seconds for the blink.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= ESTADO_ESPERA;
      ini_q       <= 1'b0;
      presc_q     <= '0;
      seg_q       <= 4'd0;
      bola_q      <= 1'b0;
      recentra_q  <= 1'b0;
      saque_dir_q <= 1'b1;
      pisca_q     <= 1'b0;
      esq_q       <= 4'd0;
      dir_q       <= 4'd0;
      venc_q      <= VENC_NENHUM;
    end else begin
      ini_q      <= iniciar;
      recentra_q <= 1'b0;
      case (estado_q)
        ESTADO_ESPERA: begin
          if (ini_d) begin
            estado_q   <= ESTADO_SAQUE;
            recentra_q <= 1'b1;
            presc_q    <= '0;
            seg_q      <= SEG_INI;
          end
        end
        ESTADO_SAQUE: begin
          if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            if (seg_q == 4'd1) begin
              estado_q <= ESTADO_JOGO;
              bola_q   <= 1'b1;
            end else begin
              seg_q <= seg_q - 4'd1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        ESTADO_JOGO: begin
          if (gol_esq && !gol_dir) begin
            esq_q       <= incr_sat(esq_q);
            saque_dir_q <= 1'b1;
            bola_q      <= 1'b0;
            estado_q    <= ESTADO_PONTO;
          end else if (gol_dir && !gol_esq) begin
            dir_q       <= incr_sat(dir_q);
            saque_dir_q <= 1'b0;
            bola_q      <= 1'b0;
            estado_q    <= ESTADO_PONTO;
          end
        end
        ESTADO_PONTO: begin
          if (esq_q == PV || dir_q == PV) begin
            estado_q <= ESTADO_FIM;
            venc_q   <= (esq_q == PV) ? VENC_ESQ : VENC_DIR;
            presc_q  <= '0;
            pisca_q  <= 1'b1;
          end else begin
            estado_q   <= ESTADO_SAQUE;
            recentra_q <= 1'b1;
            presc_q    <= '0;
            seg_q      <= SEG_INI;
          end
        end
        ESTADO_FIM: begin
          if (ini_d) begin
            esq_q       <= 4'd0;
            dir_q       <= 4'd0;
            venc_q      <= VENC_NENHUM;
            saque_dir_q <= 1'b1;
            pisca_q     <= 1'b0;
            estado_q    <= ESTADO_SAQUE;
            recentra_q  <= 1'b1;
            presc_q     <= '0;
            seg_q       <= SEG_INI;
          end else if (presc_q == MEIO_MAX) begin
            presc_q <= '0;
            pisca_q <= ~pisca_q;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: estado_q <= ESTADO_ESPERA;
      endcase
    end
  end

  assign bola_liberada = bola_q;
  assign recentra      = recentra_q;
  assign saque_dir     = saque_dir_q;
  assign placar_esq    = esq_q;
  assign placar_dir    = dir_q;
  assign vencedor      = venc_q;

  logic apaga_esq, apaga_dir, apaga_seg, apaga_venc;
  assign apaga_esq  = (estado_q == ESTADO_FIM) && pisca_q && (venc_q == VENC_ESQ);
  assign apaga_dir  = (estado_q == ESTADO_FIM) && pisca_q && (venc_q == VENC_DIR);
  assign apaga_seg  = (estado_q != ESTADO_SAQUE);
  assign apaga_venc = (estado_q != ESTADO_FIM);

  hex7seg u_hex5 (.valor_i(dezena(esq_q)),    .apagado_i(apaga_esq),  .seg_o(HEX5));
  hex7seg u_hex4 (.valor_i(unidade(esq_q)),   .apagado_i(apaga_esq),  .seg_o(HEX4));
  hex7seg u_hex3 (.valor_i(dezena(dir_q)),    .apagado_i(apaga_dir),  .seg_o(HEX3));
  hex7seg u_hex2 (.valor_i(unidade(dir_q)),   .apagado_i(apaga_dir),  .seg_o(HEX2));
  hex7seg u_hex1 (.valor_i(seg_q),            .apagado_i(apaga_seg),  .seg_o(HEX1));
  hex7seg u_hex0 (.valor_i({2'b00, venc_q}),  .apagado_i(apaga_venc), .seg_o(HEX0));

endmodule

// File: tb/tb_placar_partida.sv
// Scoreboard bench for placar_partida: a behavioural match model predicts every
// output each cycle and a separate monitor compares after each clock edge.
module tb_placar_partida;

  localparam int C  = 4;
  localparam int S  = 3;
  localparam int PV = 3;

  localparam int WAIT  = 0;
  localparam int SERVE = 1;
  localparam int PLAY  = 2;
  localparam int POINT = 3;
  localparam int OVER  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, iniciar = 1'b0, gol_esq = 1'b0, gol_dir = 1'b0;
  logic bola_liberada, recentra, saque_dir;
  logic [3:0] placar_esq, placar_dir;
  logic [1:0] vencedor;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  always #5 clk = ~clk;

  placar_partida #(
    .PONTOS_VITORIA(PV),
    .CICLOS_SEGUNDO(C),
    .SAQUE_SEGUNDOS(S)
  ) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar),
    .gol_esq(gol_esq), .gol_dir(gol_dir),
    .bola_liberada(bola_liberada), .recentra(recentra), .saque_dir(saque_dir),
    .placar_esq(placar_esq), .placar_dir(placar_dir), .vencedor(vencedor),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  typedef struct packed {
    logic            bola;
    logic            rec;
    logic            sdir;
    logic [3:0]      pe;
    logic [3:0]      pd;
    logic [1:0]      venc;
    logic [5:0][6:0] hex;
  } snap_t;

  snap_t expQ[$];
  int vectors = 0;
  int miscompares = 0;

  // Model: mode plus elapsed cycles inside the current serve or match-over phase.
  int mMode = WAIT, mT = 0, mPe = 0, mPd = 0, mVenc = 0;
  bit mSdir = 1'b1, mRec = 1'b0, mIniPrev = 1'b0;

  function automatic logic [6:0] digitSeg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic void startServe();
    mMode = SERVE;
    mT    = 0;
    mRec  = 1'b1;
  endfunction

  function automatic void modelStep(input bit r, input bit i, input bit ge, input bit gd);
    bit edgeIni;
    if (r) begin
      mMode = WAIT; mT = 0; mPe = 0; mPd = 0; mVenc = 0;
      mSdir = 1'b1; mRec = 1'b0; mIniPrev = 1'b0;
      return;
    end
    edgeIni  = i && !mIniPrev;
    mIniPrev = i;
    mRec     = 1'b0;
    case (mMode)
      WAIT:  if (edgeIni) startServe();
      SERVE: if (mT == S * C - 1) mMode = PLAY; else mT++;
      PLAY: begin
        if (ge && !gd) begin
          mPe = (mPe < 15) ? mPe + 1 : 15; mSdir = 1'b1; mMode = POINT;
        end else if (gd && !ge) begin
          mPd = (mPd < 15) ? mPd + 1 : 15; mSdir = 1'b0; mMode = POINT;
        end
      end
      POINT: begin
        if (mPe == PV)      begin mMode = OVER; mVenc = 1; mT = 0; end
        else if (mPd == PV) begin mMode = OVER; mVenc = 2; mT = 0; end
        else startServe();
      end
      default: begin
        if (edgeIni) begin
          mPe = 0; mPd = 0; mVenc = 0; mSdir = 1'b1;
          startServe();
        end else mT++;
      end
    endcase
  endfunction

  function automatic snap_t expected();
    snap_t e;
    bit blinkOff;
    e.bola = (mMode == PLAY);
    e.rec  = mRec;
    e.sdir = mSdir;
    e.pe   = 4'(mPe);
    e.pd   = 4'(mPd);
    e.venc = 2'(mVenc);
    blinkOff = (mMode == OVER) && (((mT / (C / 2)) % 2) == 0);
    e.hex[5] = (blinkOff && mVenc == 1) ? 7'h7F : digitSeg(mPe / 10);
    e.hex[4] = (blinkOff && mVenc == 1) ? 7'h7F : digitSeg(mPe % 10);
    e.hex[3] = (blinkOff && mVenc == 2) ? 7'h7F : digitSeg(mPd / 10);
    e.hex[2] = (blinkOff && mVenc == 2) ? 7'h7F : digitSeg(mPd % 10);
    e.hex[1] = (mMode == SERVE) ? digitSeg(S - mT / C) : 7'h7F;
    e.hex[0] = (mMode == OVER) ? digitSeg(mVenc) : 7'h7F;
    return e;
  endfunction

  task automatic cmpField(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input snap_t e);
    vectors++;
    cmpField("bola_liberada", int'(bola_liberada), int'(e.bola));
    cmpField("recentra",      int'(recentra),      int'(e.rec));
    cmpField("saque_dir",     int'(saque_dir),     int'(e.sdir));
    cmpField("placar_esq",    int'(placar_esq),    int'(e.pe));
    cmpField("placar_dir",    int'(placar_dir),    int'(e.pd));
    cmpField("vencedor",      int'(vencedor),      int'(e.venc));
    cmpField("HEX5", int'(HEX5), int'(e.hex[5]));
    cmpField("HEX4", int'(HEX4), int'(e.hex[4]));
    cmpField("HEX3", int'(HEX3), int'(e.hex[3]));
    cmpField("HEX2", int'(HEX2), int'(e.hex[2]));
    cmpField("HEX1", int'(HEX1), int'(e.hex[1]));
    cmpField("HEX0", int'(HEX0), int'(e.hex[0]));
  endtask

  // Drive one cycle of inputs away from the active edge and queue the prediction.
  task automatic applyStimulus(input bit r, input bit i, input bit ge, input bit gd);
    @(negedge clk);
    reset = r; iniciar = i; gol_esq = ge; gol_dir = gd;
    modelStep(r, i, ge, gd);
    expQ.push_back(expected());
  endtask

  task automatic idleUntil(input int mode, input int maxCycles, input string what);
    int n = 0;
    while (mMode != mode && n < maxCycles) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (mMode != mode) begin
      miscompares++;
      $display("[TB] FAIL timeout %s: model mode %0d, wanted %0d", what, mMode, mode);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        snap_t e;
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : driver
    int guard;
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idleUntil(PLAY, 20, "first serve");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idleUntil(PLAY, 20, "serve after right goal");

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idleUntil(PLAY, 20, "serve with ignored inputs");

    guard = 0;
    while (mMode != OVER && guard < 200) begin
      if (mMode == PLAY) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      else               applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (mMode != OVER) begin
      miscompares++;
      $display("[TB] FAIL timeout reaching match over: model mode %0d", mMode);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    guard = 0;
    while (!(mMode == SERVE && mT == C) && guard < 30) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (!(mMode == SERVE && mT == C)) begin
      miscompares++;
      $display("[TB] FAIL timeout reaching mid countdown: model mode %0d", mMode);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom % 400) == 0, ($urandom % 6) == 0,
                    ($urandom % 5) == 0, ($urandom % 5) == 0);
    end

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: %0d left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
